// File: rtl/reg_file_sync_clr.sv
// Register file with 2**W entries of N bits: one synchronous write port, one combinational read port,
// and a synchronous active-low clear. The optional write-first read forwarding is enabled by REG_FILE_BYPASS_EN.
module reg_file_sync_clr #(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         wr_en,
  input  logic [W-1:0] w_addr,
  input  logic [W-1:0] r_addr,
  input  logic [N-1:0] w_data,
  output logic [N-1:0] r_data
);

  localparam int DEPTH = 1 << W;

  logic [N-1:0] mem_q [DEPTH];
  logic [N-1:0] mem_d [DEPTH];

  // Clear outranks write: a write on a clear edge is dropped.
  always_comb begin
    mem_d = mem_q;
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
    end else if (wr_en) begin
      mem_d[w_addr] = w_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef REG_FILE_BYPASS_EN
  // Forward pending write data; forwarding is suppressed while clear is asserted.
  always_comb begin
    r_data = mem_q[r_addr];
    if (wr_en && clr_n && (r_addr == w_addr)) begin
      r_data = w_data;
    end
  end
`else
  always_comb begin
    r_data = mem_q[r_addr];
  end
`endif

endmodule

// File: tb/tb_reg_file_sync_clr.sv
// Self-checking bench for reg_file_sync_clr: directed scenarios followed by random traffic,
// checked against an array model of the register contents.
module tb_reg_file_sync_clr;

  localparam int N = 8;
  localparam int W = 2;
  localparam int DEPTH = 1 << W;

  logic         clk;
  logic         clr_n;
  logic         wr_en;
  logic [W-1:0] w_addr;
  logic [W-1:0] r_addr;
  logic [N-1:0] w_data;
  logic [N-1:0] r_data;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] ref_mem [DEPTH];

  reg_file_sync_clr #(.N(N), .W(W)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .wr_en  (wr_en),
    .w_addr (w_addr),
    .r_addr (r_addr),
    .w_data (w_data),
    .r_data (r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected r_data for address a, given the current inputs.
  function automatic logic [N-1:0] visible(input logic [W-1:0] a);
`ifdef REG_FILE_BYPASS_EN
    if (wr_en && clr_n && (a == w_addr)) return w_data;
`endif
    return ref_mem[a];
  endfunction

  // One rising edge: apply the same rules to the model, then settle.
  task automatic do_edge();
    @(posedge clk);
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else if (wr_en) begin
      ref_mem[w_addr] = w_data;
    end
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; wr_en = 1'b1; w_addr = 2'd1; w_data = 8'hA5; r_addr = 2'd0;
    do_edge();
    clr_n = 1'b1; wr_en = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      r_addr = W'(a);
      #1;
      total++;
      if (r_data !== 8'h00) begin
        bad++;
        $display("FAIL reset_addr%0d: got %h want %h", a, r_data, 8'h00);
      end
    end
  endtask

  task automatic test_write();
    clr_n = 1'b1; wr_en = 1'b1; w_addr = 2'd2; w_data = 8'hBB; r_addr = 2'd2;
    do_edge();
    total++;
    if (r_data !== 8'hBB) begin
      bad++;
      $display("FAIL write_bb: got %h want %h", r_data, 8'hBB);
    end
    w_addr = 2'd3; w_data = 8'hF0; r_addr = 2'd3;
    #1;
    total++;
    if (r_data !== visible(2'd3)) begin
      bad++;
      $display("FAIL write_f0_pre: got %h want %h", r_data, visible(2'd3));
    end
    do_edge();
    total++;
    if (r_data !== 8'hF0) begin
      bad++;
      $display("FAIL write_f0_post: got %h want %h", r_data, 8'hF0);
    end
  endtask

  task automatic test_hold();
    wr_en = 1'b0; w_addr = 2'd0; w_data = 8'hF0; r_addr = 2'd2;
    #1;
    total++;
    if (r_data !== 8'hBB) begin
      bad++;
      $display("FAIL hold_read: got %h want %h", r_data, 8'hBB);
    end
    do_edge();
    r_addr = 2'd0;
    #1;
    total++;
    if (r_data !== 8'h00) begin
      bad++;
      $display("FAIL hold_entry0: got %h want %h", r_data, 8'h00);
    end
  endtask

  task automatic test_clear();
    clr_n = 1'b0; wr_en = 1'b0; r_addr = 2'd2;
    #1;
    total++;
    if (r_data !== 8'hBB) begin
      bad++;
      $display("FAIL clear_pre: got %h want %h", r_data, 8'hBB);
    end
    do_edge();
    total++;
    if (r_data !== 8'h00) begin
      bad++;
      $display("FAIL clear_post2: got %h want %h", r_data, 8'h00);
    end
    r_addr = 2'd3;
    #1;
    total++;
    if (r_data !== 8'h00) begin
      bad++;
      $display("FAIL clear_post3: got %h want %h", r_data, 8'h00);
    end
  endtask

  task automatic test_clear_priority();
    // Give entry 1 a nonzero value so a dropped clear would be visible.
    clr_n = 1'b1; wr_en = 1'b1; w_addr = 2'd1; w_data = 8'h33; r_addr = 2'd1;
    do_edge();
    clr_n = 1'b0; w_data = 8'h5A;
    #1;
    total++;
    if (r_data !== 8'h33) begin
      bad++;
      $display("FAIL prio_pre: got %h want %h", r_data, 8'h33);
    end
    do_edge();
    clr_n = 1'b1; wr_en = 1'b0;
    #1;
    total++;
    if (r_data !== 8'h00) begin
      bad++;
      $display("FAIL prio_post: got %h want %h", r_data, 8'h00);
    end
    wr_en = 1'b1; w_addr = 2'd1; w_data = 8'h5A; r_addr = 2'd1;
    #1;
    total++;
`ifdef REG_FILE_BYPASS_EN
    if (r_data !== 8'h5A) begin
      bad++;
      $display("FAIL bypass_pre: got %h want %h", r_data, 8'h5A);
    end
`else
    if (r_data !== 8'h00) begin
      bad++;
      $display("FAIL nobypass_pre: got %h want %h", r_data, 8'h00);
    end
`endif
    do_edge();
    wr_en = 1'b0;
    #1;
    total++;
    if (r_data !== 8'h5A) begin
      bad++;
      $display("FAIL prio_write_after: got %h want %h", r_data, 8'h5A);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 300; it++) begin
      clr_n  = ($urandom_range(0, 15) != 0);
      wr_en  = ($urandom_range(0, 3) != 0);
      w_addr = W'($urandom_range(0, DEPTH - 1));
      w_data = N'($urandom);
      r_addr = ($urandom_range(0, 2) == 0) ? w_addr : W'($urandom_range(0, DEPTH - 1));
      #1;
      total++;
      if (r_data !== visible(r_addr)) begin
        bad++;
        $display("FAIL rand_pre it%0d a%0d: got %h want %h", it, r_addr, r_data, visible(r_addr));
      end
      do_edge();
      clr_n = 1'b1; wr_en = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
        r_addr = W'(a);
        #1;
        total++;
        if (r_data !== ref_mem[a]) begin
          bad++;
          $display("FAIL rand_post it%0d a%0d: got %h want %h", it, a, r_data, ref_mem[a]);
        end
      end
    end
  endtask

  initial begin
    clr_n = 1'b1; wr_en = 1'b0; w_addr = '0; r_addr = '0; w_data = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    #2;
    test_reset();
    test_write();
    test_hold();
    test_clear();
    test_clear_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
